stream_demux_1_4: RTL and testbench
===================================

Name: stream_demux_1_4

Overview:
- Sequential counterpart of the team's 4:1 mux tree: a 1-to-4 stream demultiplexer.
- Takes one valid/ready input stream, with a 2-bit destination select per word, and routes each word to one of four output streams.
- Each output lane has its own small FIFO, so a stalled lane does not block traffic to the other lanes except when that stalled lane is the one selected.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 2, entries per output lane FIFO; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  demux accepts the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination lane for in_data; qualified by in_valid.
- out_valid  output  4  bit i set means lane i has a word at its head.
- out_ready  input  4  bit i set means consumer i takes the head word this cycle.
- out_data0  output  WIDTH  head word of lane 0.
- out_data1  output  WIDTH  head word of lane 1.
- out_data2  output  WIDTH  head word of lane 2.
- out_data3  output  WIDTH  head word of lane 3.

Behaviour:
- Reset:
  - One clock, sampled on the rising edge of clk.
  - While rst=1 at an edge: all lane FIFOs empty, read/write pointers 0, counts 0, storage cleared to 0.
  - After reset: out_valid=4'b0000, out_data0..3=0, in_ready=1.
  - Reset mid-operation discards all buffered words; no word is emitted after reset that was accepted before it.
- Per-lane state: FIFO with storage[DEPTH], wr_ptr and rd_ptr of log2(DEPTH) bits, and a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- Lane flags: full_i = (count_i==DEPTH); empty_i = (count_i==0).
- in_ready = ~full[in_sel]. This is combinational from in_sel and the registered counts only; it does not depend on out_ready (no pop-to-push bypass).
- Push: when in_valid & in_ready at an edge, in_data is written to lane in_sel at wr_ptr, then wr_ptr and count of that lane update. Exactly one lane is pushed per cycle at most.
- Pop: out_valid[i] = ~empty_i. When out_valid[i] & out_ready[i] at an edge, rd_ptr_i advances and count_i decrements. All four lanes may pop in the same cycle.
- Simultaneous push and pop on the same lane: count unchanged, both pointers advance.
- Push into a full lane cannot occur, because in_ready=0.
- Head data: out_dataN = storage_N[rd_ptr_N]. While the lane is empty the value is the stale last entry and is don't-care for the consumer.
- Latency: a word pushed into an empty lane appears on out_valid/out_dataN on the cycle after acceptance. It is never visible in the same cycle.
- Ordering: each lane is strictly FIFO. There is no ordering guarantee across lanes.
- Throughput: one word per cycle into any lane whose consumer holds out_ready=1; a sustained stream into one lane runs at full rate.
- Head-of-line blocking: if the selected lane is full, the producer stalls. The producer must hold in_valid, in_data and in_sel stable until the handshake completes.
- in_sel while in_valid=0: ignored; in_ready still reflects the lane it selects.
- X on in_sel while in_valid=0 must not corrupt state.

Test Plan:
- Reset then idle -> out_valid=0000, in_ready=1, out_data0..3=0 for 5 cycles.
- Push in_data=4'hA, in_sel=2 with out_ready=0000 -> cycle+1: out_valid=0100, out_data2=A. Pop with out_ready=0100 -> next cycle out_valid=0000.
- Fill lane 1 with 3,5 (out_ready=0) -> in_ready=0 when in_sel=1 and 1 when in_sel=0. Push 7 to lane 0 succeeds. Drain lane 1 -> outputs 3 then 5, in order.
- Lane 3 full with 1,2; assert out_ready[3] and offer 9 to lane 3 -> in_ready=0 that cycle (no bypass), accepted next cycle. Lane 3 then yields 2 then 9.
- Streaming 0..15 with in_sel=i%4, out_ready=1111 -> no stalls after the first cycle; each lane outputs its own subsequence in order, e.g. lane 1 outputs 1,5,9,13.
- Two words buffered in lanes 0 and 2, assert rst for 1 cycle -> out_valid=0000 and no stale word emitted afterwards; next push has latency 1.

Source files
------------

// File: rtl/stream_demux_1_4_if.sv
// Stream bundle for the 1-to-4 demux: one valid/ready input stream with a
// lane select, and four valid/ready output streams with their head words.
interface stream_demux_1_4_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_data0;
   logic [WIDTH-1:0] out_data1;
   logic [WIDTH-1:0] out_data2;
   logic [WIDTH-1:0] out_data3;

   // Producer and consumers side
   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );

   // Demux side
   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );
endinterface

// File: rtl/stream_demux_1_4.sv
// 1-to-4 stream demultiplexer. Each input word is routed to the lane named by
// in_sel and buffered in that lane's own FIFO, so only a full selected lane
// stalls the producer. in_ready looks at registered counts only; a pop on the
// selected full lane frees space for the following cycle, not the current one.
module stream_demux_1_4 #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input logic                clk,
   input logic                rst,
   stream_demux_1_4_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem    [4][DEPTH];
   logic [PW-1:0]    r_wr_ptr [4];
   logic [PW-1:0]    r_rd_ptr [4];
   logic [CW-1:0]    r_count  [4];

   logic [3:0] w_full;
   logic [3:0] w_empty;
   logic [3:0] w_push;
   logic [3:0] w_pop;
   logic       w_accept;

   // Per-lane full/empty flags from the registered counts
   always_comb begin
      w_full  = '0;
      w_empty = '0;
      for (int l = 0; l < 4; l++) begin
         w_full[l]  = (r_count[l] == FULL_CNT);
         w_empty[l] = (r_count[l] == '0);
      end
   end

   assign bus.in_ready  = ~w_full[bus.in_sel];
   assign w_accept      = bus.in_valid & bus.in_ready;
   assign bus.out_valid = ~w_empty;

   // Push decode is gated by in_valid so a floating in_sel while idle is harmless
   always_comb begin
      w_push = '0;
      w_pop  = '0;
      for (int l = 0; l < 4; l++) begin
         w_push[l] = w_accept & (bus.in_sel == 2'(l));
         w_pop[l]  = ~w_empty[l] & bus.out_ready[l];
      end
   end

   assign bus.out_data0 = r_mem[0][r_rd_ptr[0]];
   assign bus.out_data1 = r_mem[1][r_rd_ptr[1]];
   assign bus.out_data2 = r_mem[2][r_rd_ptr[2]];
   assign bus.out_data3 = r_mem[3][r_rd_ptr[3]];

   // Lane FIFO storage, pointers and counts
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < 4; l++) begin
            r_wr_ptr[l] <= '0;
            r_rd_ptr[l] <= '0;
            r_count[l]  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               r_mem[l][e] <= '0;
            end
         end
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (w_push[l]) begin
               r_mem[l][r_wr_ptr[l]] <= bus.in_data;
               r_wr_ptr[l]           <= r_wr_ptr[l] + PW'(1);
            end
            if (w_pop[l]) begin
               r_rd_ptr[l] <= r_rd_ptr[l] + PW'(1);
            end
            case ({w_push[l], w_pop[l]})
               2'b10:   r_count[l] <= r_count[l] + CW'(1);
               2'b01:   r_count[l] <= r_count[l] - CW'(1);
               default: r_count[l] <= r_count[l];
            endcase
         end
      end
   end
endmodule

// File: tb/tb_stream_demux_1_4.sv
module tb_stream_demux_1_4;
   localparam int WIDTH = 4;
   localparam int DEPTH = 2;

   logic clk;
   logic rst;

   stream_demux_1_4_if #(.WIDTH(WIDTH)) bus ();

   stream_demux_1_4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: per-lane queues of accepted, not yet consumed words
   logic [WIDTH-1:0] mq [4][$];
   bit   [3:0]       pushed_since_rst;
   bit               model_ok = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] dut_data(input int l);
      case (l)
         0:       return bus.out_data0;
         1:       return bus.out_data1;
         2:       return bus.out_data2;
         default: return bus.out_data3;
      endcase
   endfunction

   // Model update on each rising edge, from the inputs and the pre-edge queues
   always @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < 4; l++) mq[l].delete();
         pushed_since_rst = '0;
         model_ok = 1;
      end else if (model_ok) begin
         bit [3:0] pop;
         bit       push;
         int       s;
         s = int'(bus.in_sel);
         for (int l = 0; l < 4; l++) pop[l] = bus.out_ready[l] && (mq[l].size() > 0);
         push = bus.in_valid && (mq[s].size() < DEPTH);
         for (int l = 0; l < 4; l++) if (pop[l]) void'(mq[l].pop_front());
         if (push) begin
            mq[s].push_back(bus.in_data);
            pushed_since_rst[s] = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (model_ok && !rst) begin
         chk("in_ready", 32'(bus.in_ready), 32'(mq[int'(bus.in_sel)].size() < DEPTH));
         for (int l = 0; l < 4; l++) begin
            chk($sformatf("out_valid[%0d]", l), 32'(bus.out_valid[l]), 32'(mq[l].size() > 0));
            if (mq[l].size() > 0)
               chk($sformatf("out_data%0d", l), 32'(dut_data(l)), 32'(mq[l][0]));
            else if (!pushed_since_rst[l])
               chk($sformatf("out_data%0d_rst", l), 32'(dut_data(l)), 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [1:0] sel, input logic [WIDTH-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_data  = d;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int stalls;
      bit accepted;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 2'd0;
      bus.in_data   = '0;
      bus.out_ready = 4'b0000;
      step();
      step();
      rst = 1'b0;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_valid", 32'(bus.out_valid), 32'h0);
         chk("idle_ready", 32'(bus.in_ready), 32'h1);
         chk("idle_data", {16'h0, bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0}, 32'h0);
         step();
      end

      // Single word to lane 2, latency one cycle, then pop
      push_one(2'd2, 4'hA);
      bus.out_ready = 4'b0100;
      @(negedge clk);
      chk("l2_valid", 32'(bus.out_valid), 32'h4);
      chk("l2_data", 32'(bus.out_data2), 32'hA);
      step();
      bus.out_ready = 4'b0000;
      @(negedge clk);
      chk("l2_popped", 32'(bus.out_valid), 32'h0);
      step();

      // Fill lane 1, other lanes stay open
      push_one(2'd1, 4'h3);
      push_one(2'd1, 4'h5);
      bus.in_sel = 2'd1;
      @(negedge clk);
      chk("l1_full_ready", 32'(bus.in_ready), 32'h0);
      step();
      bus.in_sel = 2'd0;
      @(negedge clk);
      chk("l0_open_ready", 32'(bus.in_ready), 32'h1);
      push_one(2'd0, 4'h7);
      bus.out_ready = 4'b0010;
      @(negedge clk);
      chk("l01_valid", 32'(bus.out_valid), 32'h3);
      chk("l1_first", 32'(bus.out_data1), 32'h3);
      step();
      @(negedge clk);
      chk("l1_second", 32'(bus.out_data1), 32'h5);
      step();
      bus.out_ready = 4'b0001;
      @(negedge clk);
      chk("l0_only", 32'(bus.out_valid), 32'h1);
      chk("l0_data", 32'(bus.out_data0), 32'h7);
      step();
      bus.out_ready = 4'b0000;

      // Full lane 3 with consumer ready: no same-cycle bypass
      push_one(2'd3, 4'h1);
      push_one(2'd3, 4'h2);
      bus.out_ready = 4'b1000;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd3;
      bus.in_data   = 4'h9;
      @(negedge clk);
      chk("l3_nobypass", 32'(bus.in_ready), 32'h0);
      chk("l3_head1", 32'(bus.out_data3), 32'h1);
      step();
      @(negedge clk);
      chk("l3_ready_next", 32'(bus.in_ready), 32'h1);
      chk("l3_head2", 32'(bus.out_data3), 32'h2);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("l3_head9", 32'(bus.out_data3), 32'h9);
      chk("l3_valid", 32'(bus.out_valid), 32'h8);
      step();
      bus.out_ready = 4'b0000;
      @(negedge clk);
      chk("l3_drained", 32'(bus.out_valid), 32'h0);

      // Streaming 0..15 round robin at full rate
      step();
      bus.out_ready = 4'b1111;
      stalls = 0;
      for (int i = 0; i < 17; i++) begin
         bus.in_valid = (i < 16);
         bus.in_sel   = 2'(i % 4);
         bus.in_data  = 4'(i);
         @(negedge clk);
         if (i < 16 && !bus.in_ready) stalls++;
         if (i >= 1 && ((i - 1) % 4) == 1) begin
            chk("stream_l1_valid", 32'(bus.out_valid), 32'h2);
            chk("stream_l1_data", 32'(bus.out_data1), 32'(i - 1));
         end
         step();
      end
      bus.in_valid = 1'b0;
      chk("stream_stalls", 32'(stalls), 32'h0);
      bus.out_ready = 4'b0000;

      // Reset discards buffered words
      push_one(2'd0, 4'h4);
      push_one(2'd2, 4'h6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
         chk("post_rst_data", {16'h0, bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0}, 32'h0);
         step();
      end
      push_one(2'd0, 4'hB);
      @(negedge clk);
      chk("post_rst_lat", 32'(bus.out_valid), 32'h1);
      chk("post_rst_word", 32'(bus.out_data0), 32'hB);
      step();

      // Randomized traffic; producer holds an offer until it is taken
      bus.in_valid = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!bus.in_valid || accepted) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_sel   = 2'($urandom_range(0, 3));
            bus.in_data  = 4'($urandom);
         end
         bus.out_ready = 4'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         @(negedge clk);
         accepted = bus.in_valid && bus.in_ready;
         step();
         if (rst) begin
            rst = 1'b0;
            bus.in_valid = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
